// File: rtl/sd_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module  : sd_cmd_master_if
// Purpose : Bundles the link between the SD command master and the serial
//           command host. It carries the setting and command words, the
//           REQ/ACK handshake in both directions, and the host status and
//           response.
//   master : drives SETTING_OUT, CMD_OUT, REQ_OUT, ACK_OUT;
//            samples REQ_IN, ACK_IN, STATUS_IN, RSP_IN
//   slave  : the serial host side, with the opposite directions
// Rev     : 1.0  initial release
// ============================================================================
interface sd_cmd_master_if;
  logic [15:0] SETTING_OUT;
  logic [39:0] CMD_OUT;
  logic        REQ_OUT;
  logic        ACK_OUT;
  logic        REQ_IN;
  logic        ACK_IN;
  logic [7:0]  STATUS_IN;
  logic [39:0] RSP_IN;

  modport master (
    output SETTING_OUT, CMD_OUT, REQ_OUT, ACK_OUT,
    input  REQ_IN, ACK_IN, STATUS_IN, RSP_IN
  );

  modport slave (
    input  SETTING_OUT, CMD_OUT, REQ_OUT, ACK_OUT,
    output REQ_IN, ACK_IN, STATUS_IN, RSP_IN
  );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : sd_cmd_master
// Purpose : Sequences one SD command. It takes the command from the register
//           block, hands it to the serial host, waits for the response,
//           checks CRC status and guards the whole exchange with a timeout.
//           On a timeout it pulses a reset to the host.
// Ports   : SD_CLK_IN / RST_IN  clock / async active-high reset
//           NEW_CMD, CMD_IDX, CMD_ARG, RSP_TYPE, CRC_CHK, BLK_RD, BLK_WR,
//           WORD_SEL, TIMEOUT     command request from the register block
//           HOST (master)         serial host handshake and data
//           BUSY, DONE, ERR_TO, ERR_CRC, RSP_OUT, RSP_IDX   status / result
//           HOST_RST_OUT          host reset after a timeout
// Rev     : 1.0  initial release
// ============================================================================
module sd_cmd_master #(
  parameter int         TIMEOUT_W = 16,
  parameter logic [2:0] NCC       = 3'd7
) (
  input  wire                   SD_CLK_IN,
  input  wire                   RST_IN,
  input  wire                   NEW_CMD,
  input  wire  [5:0]            CMD_IDX,
  input  wire  [31:0]           CMD_ARG,
  input  wire  [1:0]            RSP_TYPE,
  input  wire                   CRC_CHK,
  input  wire                   BLK_RD,
  input  wire                   BLK_WR,
  input  wire  [1:0]            WORD_SEL,
  input  wire  [TIMEOUT_W-1:0]  TIMEOUT,
  sd_cmd_master_if.master       HOST,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR_TO,
  output logic                  ERR_CRC,
  output logic [31:0]           RSP_OUT,
  output logic [5:0]            RSP_IDX,
  output logic                  HOST_RST_OUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_RSP_ACK, S_HRST, S_FIN
  } state_t;

  state_t                 r_state, w_nxt_state;
  logic [15:0]            r_setting, w_nxt_setting;
  logic [39:0]            r_cmd, w_nxt_cmd;
  logic                   r_req, w_nxt_req;
  logic                   r_ack, w_nxt_ack;
  logic                   r_busy, w_nxt_busy;
  logic                   r_done, w_nxt_done;
  logic                   r_err_to, w_nxt_err_to;
  logic                   r_err_crc, w_nxt_err_crc;
  logic [31:0]            r_rsp, w_nxt_rsp;
  logic [5:0]             r_rsp_idx, w_nxt_rsp_idx;
  logic                   r_host_rst, w_nxt_host_rst;
  logic                   r_hrst_cnt, w_nxt_hrst_cnt;
  logic [TIMEOUT_W-1:0]   r_cnt, w_nxt_cnt;

  logic [6:0]             w_rsp_len;
  logic                   w_active;
  logic                   w_tmo;
  logic                   w_no_rsp;
  logic                   w_unused_bits;

  // Response length in bits as the serial host expects it
  always_comb begin
    case (RSP_TYPE)
      2'b01:   w_rsp_len = 7'd40;
      2'b10:   w_rsp_len = 7'd127;
      2'b11:   w_rsp_len = 7'd40;
      default: w_rsp_len = 7'd0;
    endcase
  end

  assign w_active = (r_state == S_SEND) || (r_state == S_WAIT) || (r_state == S_RSP_ACK);
  // Count reads as "cycles already spent since SEND entry"; the limit is hit in
  // the cycle where that number equals TIMEOUT.
  assign w_tmo    = w_active && (TIMEOUT != '0) && (r_cnt == TIMEOUT);
  // The latched response length tells us the type of the command in flight,
  // so a change on RSP_TYPE mid-command has no effect.
  assign w_no_rsp = (r_setting[6:0] == 7'd0);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_setting  = r_setting;
    w_nxt_cmd      = r_cmd;
    w_nxt_req      = r_req;
    w_nxt_ack      = r_ack;
    w_nxt_busy     = r_busy;
    w_nxt_done     = 1'b0;
    w_nxt_err_to   = r_err_to;
    w_nxt_err_crc  = r_err_crc;
    w_nxt_rsp      = r_rsp;
    w_nxt_rsp_idx  = r_rsp_idx;
    w_nxt_host_rst = r_host_rst;
    w_nxt_hrst_cnt = r_hrst_cnt;
    w_nxt_cnt      = r_cnt;

    if (w_active && (r_cnt != '1))
      w_nxt_cnt = r_cnt + TIMEOUT_W'(1);

    if (w_tmo) begin
      // Timeout wins over any completion seen in the same cycle
      w_nxt_err_to   = 1'b1;
      w_nxt_req      = 1'b0;
      w_nxt_ack      = 1'b0;
      w_nxt_host_rst = 1'b1;
      w_nxt_hrst_cnt = 1'b0;
      w_nxt_state    = S_HRST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (NEW_CMD) begin
            w_nxt_cmd     = {2'b01, CMD_IDX, CMD_ARG};
            w_nxt_setting = {1'b0, WORD_SEL, BLK_RD, BLK_WR, NCC,
                             CRC_CHK & (RSP_TYPE != 2'b11), w_rsp_len};
            w_nxt_err_to  = 1'b0;
            w_nxt_err_crc = 1'b0;
            w_nxt_busy    = 1'b1;
            w_nxt_req     = 1'b1;
            w_nxt_cnt     = '0;
            w_nxt_state   = S_SEND;
          end
        end
        S_SEND: begin
          // Host drops ACK_IN once it has taken the command
          if (!HOST.ACK_IN) begin
            w_nxt_req   = 1'b0;
            w_nxt_state = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_no_rsp) begin
            if (HOST.ACK_IN) begin
              w_nxt_done  = 1'b1;
              w_nxt_state = S_FIN;
            end
          end else if (HOST.REQ_IN && (HOST.STATUS_IN[3:0] == 4'b0110)) begin
            w_nxt_rsp     = HOST.RSP_IN[31:0];
            w_nxt_rsp_idx = HOST.RSP_IN[37:32];
            w_nxt_err_crc = r_setting[7] & ~HOST.STATUS_IN[5];
            w_nxt_ack     = 1'b1;
            w_nxt_state   = S_RSP_ACK;
          end
        end
        S_RSP_ACK: begin
          if (HOST.ACK_IN) begin
            w_nxt_ack   = 1'b0;
            w_nxt_done  = 1'b1;
            w_nxt_state = S_FIN;
          end
        end
        S_HRST: begin
          // Second HRST cycle ends the host reset pulse
          if (r_hrst_cnt) begin
            w_nxt_host_rst = 1'b0;
            w_nxt_done     = 1'b1;
            w_nxt_state    = S_FIN;
          end else begin
            w_nxt_hrst_cnt = 1'b1;
          end
        end
        S_FIN: begin
          w_nxt_busy  = 1'b0;
          w_nxt_state = S_IDLE;
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge SD_CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_state    <= S_IDLE;
      r_setting  <= '0;
      r_cmd      <= '0;
      r_req      <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_to   <= 1'b0;
      r_err_crc  <= 1'b0;
      r_rsp      <= '0;
      r_rsp_idx  <= '0;
      r_host_rst <= 1'b0;
      r_hrst_cnt <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_setting  <= w_nxt_setting;
      r_cmd      <= w_nxt_cmd;
      r_req      <= w_nxt_req;
      r_ack      <= w_nxt_ack;
      r_busy     <= w_nxt_busy;
      r_done     <= w_nxt_done;
      r_err_to   <= w_nxt_err_to;
      r_err_crc  <= w_nxt_err_crc;
      r_rsp      <= w_nxt_rsp;
      r_rsp_idx  <= w_nxt_rsp_idx;
      r_host_rst <= w_nxt_host_rst;
      r_hrst_cnt <= w_nxt_hrst_cnt;
      r_cnt      <= w_nxt_cnt;
    end
  end

  assign HOST.SETTING_OUT = r_setting;
  assign HOST.CMD_OUT     = r_cmd;
  assign HOST.REQ_OUT     = r_req;
  assign HOST.ACK_OUT     = r_ack;
  assign BUSY             = r_busy;
  assign DONE             = r_done;
  assign ERR_TO           = r_err_to;
  assign ERR_CRC          = r_err_crc;
  assign RSP_OUT          = r_rsp;
  assign RSP_IDX          = r_rsp_idx;
  assign HOST_RST_OUT     = r_host_rst;

  // Status and response bits this block does not interpret
  assign w_unused_bits = ^{HOST.STATUS_IN[7:6], HOST.STATUS_IN[4], HOST.RSP_IN[39:38]};

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_cmd_master
// Purpose : Self-checking bench for sd_cmd_master. Stimulus tasks act as the
//           register block and the serial host. Each launched command pushes
//           its expected result record, and a monitor compares that record
//           on every DONE pulse.
// Rev     : 1.0  initial release
// ============================================================================
module tb_sd_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_cmd;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [1:0]  rsp_type;
  logic        crc_chk, blk_rd, blk_wr;
  logic [1:0]  word_sel;
  logic [15:0] timeout;
  logic        busy, done, err_to, err_crc, host_rst;
  logic [31:0] rsp_out;
  logic [5:0]  rsp_idx;

  sd_cmd_master_if hif ();

  sd_cmd_master #(.TIMEOUT_W(16), .NCC(3'd7)) dut (
    .SD_CLK_IN    (clk),
    .RST_IN       (rst),
    .NEW_CMD      (new_cmd),
    .CMD_IDX      (cmd_idx),
    .CMD_ARG      (cmd_arg),
    .RSP_TYPE     (rsp_type),
    .CRC_CHK      (crc_chk),
    .BLK_RD       (blk_rd),
    .BLK_WR       (blk_wr),
    .WORD_SEL     (word_sel),
    .TIMEOUT      (timeout),
    .HOST         (hif.master),
    .BUSY         (busy),
    .DONE         (done),
    .ERR_TO       (err_to),
    .ERR_CRC      (err_crc),
    .RSP_OUT      (rsp_out),
    .RSP_IDX      (rsp_idx),
    .HOST_RST_OUT (host_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] cmd;
    logic [15:0] set;
    logic        eto;
    logic        ecrc;
    logic [31:0] rsp;
    logic [5:0]  idx;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  int          n_push  = 0;
  logic [31:0] m_rsp   = '0;
  logic [5:0]  m_idx   = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pulse consumes one expected record
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cmd_out",     hif.CMD_OUT,     e.cmd);
        chk("setting_out", hif.SETTING_OUT, e.set);
        chk("err_to",      err_to,          e.eto);
        chk("err_crc",     err_crc,         e.ecrc);
        chk("rsp_out",     rsp_out,         e.rsp);
        chk("rsp_idx",     rsp_idx,         e.idx);
        chk("busy_in_fin", busy,            1'b1);
      end
    end
  end

  // mode: 0 normal, 1 host silent (timeout), 2 NEW_CMD while busy and on DONE,
  //       3 reset while waiting for the response
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input logic crc, input logic bw,
                         input logic br, input logic [1:0] ws, input logic [15:0] tmo,
                         input logic [7:0] st, input logic [39:0] rsp, input int mode,
                         input logic [15:0] exp_set, input logic exp_eto,
                         input logic exp_ecrc);
    exp_t e;
    int   hr;
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; rsp_type = rt; crc_chk = crc;
    blk_wr = bw; blk_rd = br; word_sel = ws; timeout = tmo;
    new_cmd = 1'b1;
    if (mode != 3) begin
      if (rt != 2'b00 && mode != 1) begin
        m_rsp = rsp[31:0];
        m_idx = rsp[37:32];
      end
      e.cmd = {2'b01, idx, arg}; e.set = exp_set; e.eto = exp_eto;
      e.ecrc = exp_ecrc; e.rsp = m_rsp; e.idx = m_idx;
      q.push_back(e);
      n_push++;
    end
    @(negedge clk);
    new_cmd = 1'b0;
    chk("req_latency", hif.REQ_OUT, 1'b1);
    chk("busy_set", busy, 1'b1);
    hif.ACK_IN = 1'b0;
    @(negedge clk);
    chk("req_drop", hif.REQ_OUT, 1'b0);
    if (mode == 1) begin
      hr = 0;
      // Edge k after acceptance; already at k = 1
      for (int k = 1; k < 200; k++) begin
        if (k == 19) chk("err_to_early", err_to, 1'b0);
        if (k == 21) chk("err_to_set", err_to, 1'b1);
        if (host_rst) hr++;
        if (!busy) break;
        @(negedge clk);
      end
      chk("hrst_cycles", hr, 2);
      hif.ACK_IN = 1'b1;
    end else begin
      if (mode == 2) begin
        cmd_idx = 6'h3F; cmd_arg = 32'hFFFF_FFFF;
        new_cmd = 1'b1;
        @(negedge clk);
        new_cmd = 1'b0;
      end
      repeat (2) @(negedge clk);
      if (rt == 2'b00) begin
        hif.ACK_IN = 1'b1;
      end else begin
        // Strobe with the wrong status code must be ignored
        hif.REQ_IN = 1'b1; hif.STATUS_IN = 8'h25; hif.RSP_IN = 40'h3F_FFFF_FFFF;
        @(negedge clk);
        hif.REQ_IN = 1'b0;
        chk("ignored_strobe", hif.ACK_OUT, 1'b0);
        if (mode == 3) begin
          rst = 1'b1;
          @(negedge clk);
          chk("abort_flags", {hif.REQ_OUT, hif.ACK_OUT, busy, done, err_to, err_crc, host_rst}, 7'd0);
          chk("abort_regs", {hif.SETTING_OUT, hif.CMD_OUT, rsp_out, rsp_idx}, 94'd0);
          rst = 1'b0;
          hif.ACK_IN = 1'b1;
          m_rsp = '0; m_idx = '0;
          repeat (2) @(negedge clk);
          chk("abort_idle", busy, 1'b0);
          return;
        end
        hif.REQ_IN = 1'b1; hif.STATUS_IN = st; hif.RSP_IN = rsp;
        @(negedge clk);
        hif.REQ_IN = 1'b0;
        chk("ack_out_high", hif.ACK_OUT, 1'b1);
        @(negedge clk);
        chk("ack_out_hold", hif.ACK_OUT, 1'b1);
        hif.ACK_IN = 1'b1;
        @(negedge clk);
        chk("ack_out_low", hif.ACK_OUT, 1'b0);
      end
    end
    for (int i = 0; i < 200; i++) begin
      new_cmd = (mode == 2) && done;
      if (!busy) break;
      @(negedge clk);
    end
    new_cmd = 1'b0;
    chk("busy_drop", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("stay_idle", busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; new_cmd = 1'b0; cmd_idx = '0; cmd_arg = '0; rsp_type = '0;
    crc_chk = 1'b0; blk_rd = 1'b0; blk_wr = 1'b0; word_sel = '0; timeout = '0;
    hif.REQ_IN = 1'b0; hif.ACK_IN = 1'b1; hif.STATUS_IN = '0; hif.RSP_IN = '0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {hif.REQ_OUT, hif.ACK_OUT, busy, done, err_to, err_crc, host_rst}, 7'd0);
    chk("reset_regs", {hif.SETTING_OUT, hif.CMD_OUT, rsp_out, rsp_idx}, 94'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CMD0, no response
    run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 8'h00, 40'h0, 0,
            16'h0700, 1'b0, 1'b0);
    // CMD8 short response, CRC ok; large timeout must not fire
    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 16'd1000, 8'h26,
            40'h08_0000_01AA, 0, 16'h07A8, 1'b0, 1'b0);
    // CMD8 with CRC failure
    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 8'h06,
            40'h08_0000_01AA, 0, 16'h07A8, 1'b0, 1'b1);
    // Short response without CRC check: bad CRC status is not an error
    run_cmd(6'd8, 32'h1AA, 2'b11, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 8'h06,
            40'h08_0000_01AA, 0, 16'h0728, 1'b0, 1'b0);
    // Long response, host stays silent, timeout after 20
    run_cmd(6'd2, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b0, 1'b1, 2'd2, 16'd20, 8'h00,
            40'h0, 1, 16'h57FF, 1'b1, 1'b0);
    // New commands while busy and on the DONE cycle are dropped
    run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 8'h00, 40'h0, 2,
            16'h0F00, 1'b0, 1'b0);
    chk("cmd_unchanged", hif.CMD_OUT, 40'h40_0000_0000);
    // Reset while waiting for the response, then a normal command
    run_cmd(6'd8, 32'h1AA, 2'b01, 1'b1, 1'b0, 1'b0, 2'd0, 16'd0, 8'h26,
            40'h08_0000_01AA, 3, 16'h07A8, 1'b0, 1'b0);
    run_cmd(6'd0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 8'h00, 40'h0, 0,
            16'h0700, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("done_count", n_done, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_cmd_master.md
SD_CMD_MASTER -- requirements
Module: sd_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 16, width of response timeout counter and TIMEOUT port.
REQ-002 SHALL have parameter NCC, default 3'd7, delay cycles placed in SETTING_OUT[10:8].
REQ-003 SHALL have port SD_CLK_IN  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port RST_IN  input  1  reset: asynchronous, active-high.
REQ-005 SHALL have port NEW_CMD  input  1  one-cycle start strobe from register block.
REQ-006 SHALL have port CMD_IDX  input  6  SD command index.
REQ-007 SHALL have port CMD_ARG  input  32  command argument.
REQ-008 SHALL have port RSP_TYPE  input  2  00 none, 01 short, 10 long, 11 short without CRC check.
REQ-009 SHALL have port CRC_CHK  input  1  response CRC check enable.
REQ-010 SHALL have ports BLK_RD, BLK_WR  input  1 each  data-block direction hints.
REQ-011 SHALL have port WORD_SEL  input  2  long-response word select.
REQ-012 SHALL have port TIMEOUT  input  TIMEOUT_W  wait-cycle limit; 0 disables timeout.
REQ-013 SHALL have port SETTING_OUT  output  16  setting word to serial host.
REQ-014 SHALL have port CMD_OUT  output  40  command word to serial host.
REQ-015 SHALL have port REQ_OUT  output  1  request to serial host.
REQ-016 SHALL have port ACK_OUT  output  1  acknowledge to serial host.
REQ-017 SHALL have port REQ_IN  input  1  status strobe from serial host.
REQ-018 SHALL have port ACK_IN  input  1  serial host ready/done; high when host idle.
REQ-019 SHALL have ports STATUS_IN  input  8 and RSP_IN  input  40  host status and response.
REQ-020 SHALL have outputs BUSY 1, DONE 1, ERR_TO 1, ERR_CRC 1, RSP_OUT 32, RSP_IDX 6, HOST_RST_OUT 1.

Function
REQ-021 SHALL accept NEW_CMD only in IDLE; when accepted, latch CMD_OUT={2'b01,CMD_IDX,CMD_ARG}, clear ERR_TO/ERR_CRC, set BUSY=1, and go to SEND.
REQ-022 SHALL ignore NEW_CMD in every other state, including the DONE cycle.
REQ-023 SHALL latch SETTING_OUT on acceptance with: [6:0] = 0/40/127/40 for RSP_TYPE 00/01/10/11; [7] = CRC_CHK & (RSP_TYPE!=11); [10:8] = NCC; [11] = BLK_WR; [12] = BLK_RD; [14:13] = WORD_SEL; [15] = 0.
REQ-024 States SHALL be IDLE, SEND, WAIT, RSP_ACK, HRST, FIN.
REQ-025 SEND: REQ_OUT=1; on ACK_IN==0 -> REQ_OUT=0 and go to WAIT in the same edge.
REQ-026 WAIT with RSP_TYPE 00: on ACK_IN==1 -> FIN.
REQ-027 WAIT with response: on REQ_IN==1 && STATUS_IN[3:0]==4'b0110 -> RSP_OUT=RSP_IN[31:0], RSP_IDX=RSP_IN[37:32], ERR_CRC=~STATUS_IN[5] when SETTING_OUT[7], else 0; go to RSP_ACK.
REQ-028 WAIT SHALL ignore REQ_IN strobes with any other STATUS_IN[3:0].
REQ-029 RSP_ACK: ACK_OUT=1 until ACK_IN==1, then ACK_OUT=0 and go to FIN.
REQ-030 Timeout counter SHALL clear on entry to SEND and increment each cycle in SEND/WAIT/RSP_ACK, saturating.
REQ-031 If TIMEOUT!=0 and count==TIMEOUT in SEND/WAIT/RSP_ACK: set ERR_TO=1, REQ_OUT=0, ACK_OUT=0, go to HRST; timeout takes priority over a simultaneous completion.
REQ-032 HRST: HOST_RST_OUT=1 for exactly 2 cycles, then go to FIN.
REQ-033 FIN: DONE=1 for one cycle, BUSY=0 on next edge, return to IDLE; ERR_*/RSP_* held until next accepted command.
REQ-034 NEW_CMD to REQ_OUT rise latency SHALL be 1 cycle.

Reset
REQ-035 On RST_IN: state IDLE; REQ_OUT, ACK_OUT, BUSY, DONE, ERR_TO, ERR_CRC, HOST_RST_OUT = 0; SETTING_OUT, CMD_OUT, RSP_OUT, RSP_IDX = 0; timeout count = 0.
REQ-036 RST_IN mid-command SHALL abort immediately with no DONE pulse.

Verification
REQ-037 CMD0 (IDX 0, ARG 0, RSP_TYPE 00) -> SETTING_OUT=16'h0700, CMD_OUT=40'h40_0000_0000; REQ_OUT drops when ACK_IN falls; DONE after ACK_IN rises; no errors.
REQ-038 CMD8 (ARG 32'h1AA, RSP_TYPE 01, CRC_CHK 1); host strobes status 6 with STATUS_IN[5]=1, RSP_IN=40'h08_0000_01AA -> RSP_OUT=32'h1AA, RSP_IDX=8, ERR_CRC=0, ACK_OUT high until ACK_IN=1.
REQ-039 Same as REQ-038 with STATUS_IN[5]=0 -> ERR_CRC=1; with RSP_TYPE 11 instead -> SETTING_OUT[7]=0, ERR_CRC=0.
REQ-040 TIMEOUT=20, host never strobes -> ERR_TO=1 at cycle 20 after SEND entry, HOST_RST_OUT high 2 cycles, then one DONE pulse.
REQ-041 NEW_CMD asserted while BUSY, and again on the DONE cycle -> both ignored; CMD_OUT unchanged; only one DONE.
REQ-042 RST_IN pulsed while in WAIT -> all outputs at reset values next cycle; a subsequent NEW_CMD runs normally.
